// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: divides clk_100MHz into pixel ticks and produces
// pixel/line counts, delayed blanking/sync decode and line/frame start pulses.
module vga_timing_gen #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int CLK_DIV    = 4,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int PIPE_DELAY = 0,
  parameter int CW         = 10
) (
  input  logic          clk_100MHz,
  input  logic          reset,
  input  logic          en,
  output logic          p_tick,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          video_on,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = H_DISPLAY + H_FRONT + H_SYNC;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = V_DISPLAY + V_FRONT + V_SYNC;
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic          HS_ACT   = (HSYNC_POL != 0);
  localparam logic          VS_ACT   = (VSYNC_POL != 0);

  logic [DW-1:0] r_div_cnt;
  logic [CW-1:0] r_h_count;
  logic [CW-1:0] r_v_count;
  logic          r_line_start;
  logic          r_frame_start;

  logic          w_tick;
  logic          w_h_last;
  logic          w_v_last;
  logic [2:0]    w_stage0;
  logic [2:0]    w_delayed;

  // Reset gates the strobe so CLK_DIV=1 cannot tick while held in reset.
  assign w_tick   = en && !reset && (r_div_cnt == DIV_LAST);
  assign w_h_last = (r_h_count == H_LAST);
  assign w_v_last = (r_v_count == V_LAST);

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (en) begin
      r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_h_count <= '0;
      r_v_count <= '0;
    end else if (w_tick) begin
      if (w_h_last) begin
        r_h_count <= '0;
        r_v_count <= w_v_last ? '0 : r_v_count + 1'b1;
      end else begin
        r_h_count <= r_h_count + 1'b1;
      end
    end
  end

  // Pulses mark the cycle after the edge that loaded h=0 (and v=0 for frames).
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= w_tick && w_h_last;
      r_frame_start <= w_tick && w_h_last && w_v_last;
    end
  end

  // Stage-0 decode packed as {vs, hs, vis}.
  assign w_stage0[0] = (32'(r_h_count) < H_DISPLAY) && (32'(r_v_count) < V_DISPLAY);
  assign w_stage0[1] = (32'(r_h_count) >= HS_START) && (32'(r_h_count) < HS_END);
  assign w_stage0[2] = (32'(r_v_count) >= VS_START) && (32'(r_v_count) < VS_END);

  generate
    if (PIPE_DELAY == 0) begin : g_no_pipe
      assign w_delayed = w_stage0;
    end else begin : g_pipe
      logic [2:0] r_pipe [PIPE_DELAY];

      always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < PIPE_DELAY; i++) begin
            r_pipe[i] <= '0;
          end
        end else if (w_tick) begin
          r_pipe[0] <= w_stage0;
          for (int i = 1; i < PIPE_DELAY; i++) begin
            r_pipe[i] <= r_pipe[i-1];
          end
        end
      end

      assign w_delayed = r_pipe[PIPE_DELAY-1];
    end
  endgenerate

  assign p_tick      = w_tick;
  assign x           = r_h_count;
  assign y           = r_v_count;
  assign video_on    = w_delayed[0] && !reset;
  assign hsync       = (w_delayed[1] && !reset) ? HS_ACT : ~HS_ACT;
  assign vsync       = (w_delayed[2] && !reset) ? VS_ACT : ~VS_ACT;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FRONT, H_SYNC, H_BACK, defaults 16, 96, 48, which set the horizontal porch/sync widths in pixel ticks.
REQ-003 SHALL have parameters V_DISPLAY, V_FRONT, V_SYNC, V_BACK, defaults 480, 10, 2, 33, which set the vertical widths in lines.
REQ-004 SHALL have parameter CLK_DIV, default 4, giving clk_100MHz cycles per pixel tick (legal range >=1).
REQ-005 SHALL have parameters HSYNC_POL, VSYNC_POL, default 0 each, giving the active sync level (0 = active-low).
REQ-006 SHALL have parameter PIPE_DELAY, default 0, giving the pixel-tick delay applied to video_on/hsync/vsync (legal range 0-7).
REQ-007 SHALL have parameter CW, default 10, the counter width; it SHALL hold H_TOTAL-1 and V_TOTAL-1.
REQ-008 SHALL have port clk_100MHz, input, 1 bit, the system clock.
REQ-009 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-010 SHALL have port en, input, 1 bit, timing-advance enable.
REQ-011 SHALL have port p_tick, output, 1 bit, pixel-tick strobe (one clk wide).
REQ-012 SHALL have ports x and y, output, CW bits each, the current horizontal and vertical counts.
REQ-013 SHALL have port video_on, output, 1 bit, visible-area flag after the PIPE_DELAY delay.
REQ-014 SHALL have ports hsync and vsync, output, 1 bit each, sync outputs after the PIPE_DELAY delay at the configured polarity.
REQ-015 SHALL have ports line_start and frame_start, output, 1 bit each, one-clk pulses.

Function
REQ-016 SHALL define H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (default 800) and V_TOTAL as the matching vertical sum (default 525).
REQ-017 SHALL run all logic on clk_100MHz only; p_tick SHALL be a clock enable and never a clock.
REQ-018 SHALL use a divider counter div_cnt that counts 0..CLK_DIV-1 while en=1 and wraps to 0.
REQ-019 SHALL drive p_tick = en && (div_cnt == CLK_DIV-1); for CLK_DIV=1, p_tick SHALL equal en.
REQ-020 SHALL, on a clk edge with p_tick=1, advance h_count; at H_TOTAL-1 it SHALL wrap to 0 and advance v_count.
REQ-021 SHALL wrap v_count from V_TOTAL-1 to 0 on the same edge that h_count wraps.
REQ-022 SHALL hold div_cnt, h_count, v_count and the delay line when en=0; p_tick SHALL be 0; on re-enable, counting SHALL resume from the held values.
REQ-023 SHALL drive x = h_count and y = v_count directly from the registers, with no delay.
REQ-024 SHALL decode stage-0 signals from the registered counts: vis = (h < H_DISPLAY) && (v < V_DISPLAY).
REQ-025 SHALL decode stage-0 hs as true for H_DISPLAY+H_FRONT <= h < H_DISPLAY+H_FRONT+H_SYNC.
REQ-026 SHALL decode stage-0 vs as true for V_DISPLAY+V_FRONT <= v < V_DISPLAY+V_FRONT+V_SYNC.
REQ-027 SHALL pass vis/hs/vs through a PIPE_DELAY-stage shift register that shifts only on p_tick; PIPE_DELAY=0 SHALL be a direct pass-through.
REQ-028 SHALL drive hsync = HSYNC_POL when delayed hs is true and ~HSYNC_POL otherwise; vsync SHALL follow the same rule with VSYNC_POL.
REQ-029 SHALL register line_start high for exactly one clk, in the cycle after the edge that loads h_count=0.
REQ-030 SHALL register frame_start high for exactly one clk, in the cycle after the edge that loads (h,v)=(0,0); line_start SHALL also pulse in that cycle.
REQ-031 SHALL emit no line_start or frame_start pulse on reset release.
REQ-032 SHALL keep pulses, tick and count updates glitch-free, with every output a register or a decode of registers.

Reset
REQ-033 SHALL, while reset=1 (asynchronously), hold div_cnt=0, h_count=0, v_count=0, all delay stages cleared, p_tick=0, video_on=0, line_start=0, frame_start=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL.
REQ-034 SHALL abort any line or frame in progress on reset assertion mid-frame; after release, timing SHALL restart from (0,0) with div_cnt=0.

Verification (defaults unless stated)
REQ-035 SHALL verify tick timing: release reset with en=1 -> p_tick is high in the 4th clk cycle, then every 4 clks; x=1 after the first tick.
REQ-036 SHALL verify line wrap: x=799 and p_tick -> x=0, y increments, line_start=1 for one clk, frame_start=0.
REQ-037 SHALL verify hsync: hsync low exactly for x=656..751 (96 ticks = 384 clks); with HSYNC_POL=1, hsync is high over that range.
REQ-038 SHALL verify frame wrap: (x,y)=(799,524) and p_tick -> (0,0), frame_start=1 and line_start=1 for one clk; vsync low for y=490..491.
REQ-039 SHALL verify the delay line: PIPE_DELAY=2 -> video_on falls 2 p_ticks after x reaches 640; hsync and vsync shift by the same 2 ticks.
REQ-040 SHALL verify stall and mid-frame reset: en=0 at x=100 for 50 clks -> x stays 100 and p_tick=0, then resumes at 101; reset asserted at y=200 -> all outputs take REQ-033 values immediately.
